// File: rtl/counter_pkg.sv
// Shared direction type and width limit for the up/down counter block.
package counter_pkg;
   typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
   localparam int MIN_WIDTH = 2;
endpackage

// File: rtl/updown_counter_core.sv
// Counting core: load/enable priority, wrap or saturate at the range ends, tc generation.
module updown_counter_core
   import counter_pkg::*;
#(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  dir_e             dir_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             sat_i,
   output logic [WIDTH-1:0] count_o,
   output logic             tc_o
);
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_tc_nxt;
   logic             w_at_bound;

   // A step is blocked or wraps only when it would leave the range in its own direction.
   always_comb begin
      w_at_bound  = (dir_i == DIR_UP) ? (r_count == ALL_ONES) : (r_count == '0);
      w_count_nxt = r_count;
      w_tc_nxt    = 1'b0;
      if (load_i) begin
         w_count_nxt = load_val_i;
      end else if (en_i) begin
         if (w_at_bound) begin
            w_tc_nxt = 1'b1;
            if (!sat_i)
               w_count_nxt = (dir_i == DIR_UP) ? '0 : ALL_ONES;
         end else begin
            w_count_nxt = (dir_i == DIR_UP) ? r_count + 1'b1 : r_count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_count <= RST_VAL;
         r_tc    <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_tc    <= w_tc_nxt;
      end
   end

   assign count_o = r_count;
   assign tc_o    = r_tc;
endmodule

// File: rtl/updown_counter_reg.sv
// Up/down counter with registered inputs and outputs around updown_counter_core.
// Define COUNTER_SAT_EN to build the sat_i register and enable saturating mode.
module updown_counter_reg
   import counter_pkg::*;
#(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             sel_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             sat_i,
   output logic [WIDTH-1:0] count_o,
   output logic             tc_o
);
   generate
      if (WIDTH < MIN_WIDTH) begin : g_width_chk
         $error("updown_counter_reg: WIDTH must be at least %0d", MIN_WIDTH);
      end
   endgenerate

   logic             r_en;
   logic             r_sel;
   logic             r_load;
   logic [WIDTH-1:0] r_load_val;
   logic             w_sat;
   dir_e             w_dir;
   logic [WIDTH-1:0] w_core_count;
   logic             w_core_tc;
   logic [WIDTH-1:0] r_count_out;
   logic             r_tc_out;

   // Input stage
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_en       <= 1'b0;
         r_sel      <= 1'b0;
         r_load     <= 1'b0;
         r_load_val <= '0;
      end else begin
         r_en       <= en_i;
         r_sel      <= sel_i;
         r_load     <= load_i;
         r_load_val <= load_val_i;
      end
   end

`ifdef COUNTER_SAT_EN
   logic r_sat;
   always_ff @(posedge clk_i) begin
      if (rst_i) r_sat <= 1'b0;
      else       r_sat <= sat_i;
   end
   assign w_sat = r_sat;
`else
   logic w_sat_unused;
   assign w_sat_unused = sat_i;
   assign w_sat        = 1'b0;
`endif

   assign w_dir = dir_e'(r_sel);

   // Core stage
   updown_counter_core #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
   ) u_core (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (r_en),
      .dir_i      (w_dir),
      .load_i     (r_load),
      .load_val_i (r_load_val),
      .sat_i      (w_sat),
      .count_o    (w_core_count),
      .tc_o       (w_core_tc)
   );

   // Output stage
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_count_out <= RST_VAL;
         r_tc_out    <= 1'b0;
      end else begin
         r_count_out <= w_core_count;
         r_tc_out    <= w_core_tc;
      end
   end

   assign count_o = r_count_out;
   assign tc_o    = r_tc_out;
endmodule

// File: tb/tb_updown_counter_reg.sv
// Bench for updown_counter_reg (WIDTH=4, RST_VAL=0): vector table, corner sequences, random vs model.
module tb_updown_counter_reg;
   localparam int          W    = 4;
   localparam logic [W-1:0] RV  = '0;
   localparam int          MAXV = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst, en, sel, load, sat;
   logic [W-1:0] lval;
   logic [W-1:0] count;
   logic         tc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   updown_counter_reg #(.WIDTH(W), .RST_VAL(RV)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .en_i       (en),
      .sel_i      (sel),
      .load_i     (load),
      .load_val_i (lval),
      .sat_i      (sat),
      .count_o    (count),
      .tc_o       (tc)
   );

   typedef struct packed {
      logic         rst;
      logic         en;
      logic         sel;
      logic         load;
      logic [W-1:0] lval;
      logic         sat;
   } in_t;

   typedef struct {
      in_t  in;
      int   ecount;
      logic etc;
   } vec_t;

   vec_t tbl[$];

`ifdef COUNTER_SAT_EN
   int sat_cnt[5] = '{13, 14, 15, 15, 15};
   bit sat_tc[5]  = '{0, 0, 0, 1, 1};
`else
   int sat_cnt[5] = '{13, 14, 15, 0, 1};
   bit sat_tc[5]  = '{0, 0, 0, 1, 0};
`endif

   // Reference: the output shows the effect of the input sampled two edges earlier.
   int  m_val;
   bit  m_tc;
   in_t d1, d2;

   function automatic in_t mk(input logic r, input logic e, input logic s,
                              input logic l, input int lv, input logic st);
      in_t x;
      x.rst = r; x.en = e; x.sel = s; x.load = l; x.lval = lv[W-1:0]; x.sat = st;
      return x;
   endfunction

   task automatic add(input in_t x, input int ec, input logic et);
      vec_t v;
      v.in = x; v.ecount = ec; v.etc = et;
      tbl.push_back(v);
   endtask

   task automatic model_edge(input in_t cur);
      int nxt;
      bit satm;
      if (cur.rst) begin
         m_val = int'(RV); m_tc = 1'b0; d1 = '0; d2 = '0;
      end else begin
         m_tc = 1'b0;
`ifdef COUNTER_SAT_EN
         satm = d2.sat;
`else
         satm = 1'b0;
`endif
         if (d2.load) begin
            m_val = int'(d2.lval);
         end else if (d2.en) begin
            nxt = d2.sel ? m_val + 1 : m_val - 1;
            if (nxt > MAXV || nxt < 0) begin
               m_tc  = 1'b1;
               m_val = satm ? m_val : (nxt + MAXV + 1) % (MAXV + 1);
            end else begin
               m_val = nxt;
            end
         end
         d2 = d1;
         d1 = cur;
      end
   endtask

   task automatic cyc(input in_t x);
      rst = x.rst; en = x.en; sel = x.sel; load = x.load; lval = x.lval; sat = x.sat;
      @(posedge clk);
      #1;
      model_edge(x);
   endtask

   task automatic chk(input string name, input int ec, input logic et);
      checks++;
      if (count !== ec[W-1:0] || tc !== et) begin
         errors++;
         $display("FAIL %s: got count=%0d tc=%0b, want count=%0d tc=%0b",
                  name, count, tc, ec, et);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; sel = 1'b0; load = 1'b0; lval = '0; sat = 1'b0;

      // Directed vectors: reset, up count, en gap with direction flip, load vs enable, down wrap.
      add(mk(1,0,0,0,0,0),  0, 0);
      add(mk(1,0,0,0,0,0),  0, 0);
      add(mk(0,1,1,0,0,0),  0, 0);
      add(mk(0,1,1,0,0,0),  0, 0);
      add(mk(0,1,1,0,0,0),  1, 0);
      add(mk(0,1,1,0,0,0),  2, 0);
      add(mk(0,0,1,0,0,0),  3, 0);
      add(mk(0,1,0,0,0,0),  4, 0);
      add(mk(0,1,0,0,0,0),  4, 0);
      add(mk(0,1,1,1,9,0),  3, 0);
      add(mk(0,1,1,0,0,0),  2, 0);
      add(mk(0,1,1,0,0,0),  9, 0);
      add(mk(0,0,0,0,0,0), 10, 0);
      add(mk(0,0,0,0,0,0), 11, 0);
      add(mk(0,0,0,0,0,0), 11, 0);
      add(mk(1,0,0,0,0,0),  0, 0);
      add(mk(0,1,0,0,0,0),  0, 0);
      add(mk(0,1,0,0,0,0),  0, 0);
      add(mk(0,0,0,0,0,0), 15, 1);
      add(mk(0,0,0,0,0,0), 14, 0);
      add(mk(0,0,0,0,0,0), 14, 0);
      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].in);
         chk($sformatf("vec%0d", i), tbl[i].ecount, tbl[i].etc);
      end

      // Full up run through the wrap.
      cyc(mk(1,0,0,0,0,0));
      for (int j = 1; j <= 19; j++) begin
         cyc(mk(0,1,1,0,0,0));
         chk($sformatf("upwrap%0d", j), (j < 3) ? 0 : (j - 2) % 16, (j - 2) == 16);
      end

      // Boundary behaviour from 13 with sat requested.
      cyc(mk(1,0,0,0,0,0));
      cyc(mk(0,0,0,1,13,1));
      cyc(mk(0,1,1,0,0,1));
      for (int j = 0; j < 5; j++) begin
         cyc(mk(0,1,1,0,0,1));
         chk($sformatf("sat%0d", j), sat_cnt[j], sat_tc[j]);
      end

      // Reset arriving mid-count.
      cyc(mk(1,0,0,0,0,0));
      for (int j = 1; j <= 9; j++) cyc(mk(0,1,1,0,0,0));
      chk("pre_rst", 7, 0);
      cyc(mk(1,1,1,0,0,0));
      chk("rst_edge", 0, 0);
      cyc(mk(0,1,1,0,0,0));
      chk("post_rst1", 0, 0);
      cyc(mk(0,1,1,0,0,0));
      chk("post_rst2", 0, 0);
      cyc(mk(0,1,1,0,0,0));
      chk("post_rst3", 1, 0);
      cyc(mk(0,1,1,0,0,0));
      chk("post_rst4", 2, 0);

      // Random traffic against the reference.
      cyc(mk(1,0,0,0,0,0));
      chk("rand_rst", m_val, m_tc);
      for (int n = 0; n < 3000; n++) begin
         cyc(mk($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 11) == 0,
                int'($urandom_range(0, MAXV)), $urandom_range(0, 1) == 1));
         chk("rand", m_val, m_tc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
